ttl_pulse_sequencer: RTL and testbench
======================================

Name: ttl_pulse_sequencer

Overview:
- Playback engine that consumes (pattern, duration) entries and drives the TTL output lines with cycle-exact dwell times.
- Sits downstream of the ttl_gen_axi master/register path. That path pushes entries through a valid/ready write port.
- This block buffers entries in an internal FIFO and plays them back-to-back on start.
- Reports busy, a done pulse and the FIFO fill level back to the control path.

Parameters:
- TTL_W, 8, number of TTL output lines.
- CNT_W, 32, width of per-entry duration in ACLK cycles.
- DEPTH, 16, FIFO depth in entries; must be a power of 2, minimum 2.

Ports:
- ACLK  input  1  system clock; all logic on rising edge.
- ARESET  input  1  asynchronous active-high reset.
- wr_valid  input  1  entry offered on wr_pattern/wr_count.
- wr_ready  output  1  FIFO can accept an entry.
- wr_pattern  input  TTL_W  TTL levels for this entry.
- wr_count  input  CNT_W  dwell in cycles; 0 is treated as 1.
- start  input  1  single-cycle pulse; begin playback.
- stop  input  1  single-cycle pulse; abort playback and flush FIFO.
- ttl_out  output  TTL_W  registered TTL lines.
- busy  output  1  high in LOAD/RUN.
- done  output  1  one-cycle pulse when the sequence ends naturally.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, asynchronous, effective immediately:
  - ttl_out=0, busy=0, done=0, level=0.
  - FIFO pointers cleared; state=IDLE.
  - wr_ready rises on the first clock after ARESET deasserts.
- Write side:
  - An entry is accepted when wr_valid&&wr_ready at a rising edge.
  - wr_ready = !full; it is never dependent on wr_valid.
  - A write and a pop in the same cycle are both honoured; level is unchanged.
  - A write while full is impossible: wr_ready=0.
  - Writes are accepted in every state, including RUN.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - ttl_out=0.
  - start && !empty -> LOAD, popping the head entry.
  - start && empty -> stays IDLE; no done pulse.
- LOAD (one cycle):
  - ttl_out<=pattern and cnt<=max(count,1); -> RUN.
  - First pattern appears on ttl_out 2 cycles after the start edge.
- RUN:
  - cnt decrements each cycle; ttl_out holds.
  - At cnt==1, if FIFO non-empty: pop; next cycle loads the new pattern and count directly and stays in RUN. There is no gap cycle, so each entry is held exactly max(count,1) cycles.
  - At cnt==1, if FIFO empty: -> DONE.
- DONE (one cycle): ttl_out<=0, done=1; -> IDLE.
- stop:
  - In any state, next cycle: state=IDLE, ttl_out=0, FIFO flushed (level=0).
  - No done pulse.
  - A write in the same cycle as stop is discarded.
- Simultaneous events:
  - stop and start in the same cycle: stop wins.
  - start while busy: ignored.
- Arithmetic:
  - cnt is CNT_W wide, unsigned.
  - Maximum dwell is 2^CNT_W-1 cycles; the counter never wraps.
  - level is exact from 0 to DEPTH.

Optional Feature:
- Macro: TTL_PULSE_SEQ_LOOP_EN.
- When defined:
  - Adds input port loop (1 bit), sampled at start.
  - If loop was set, every entry popped during playback is re-written to the FIFO tail in the same cycle, so the sequence repeats indefinitely with no gap between the last and first entry.
  - Loop ends only via stop.
  - While looping, wr_ready=0.
- When undefined: no loop port; playback is single-shot as above.

Test Plan:
- Reset mid-RUN: assert ARESET -> ttl_out=0 in the same cycle without a clock edge; level=0 after release.
- Single entry: write (0xA5, 3), start -> ttl_out=0xA5 for exactly 3 cycles starting at start+2; then 0x00; done pulses once; busy low 1 cycle after done.
- Back-to-back: write (0x01,2), (0x02,0), (0x04,5), start -> ttl_out sequence is 01,01,02,04×5,00 with no gaps; done once.
- Full FIFO:
  - Write 16 entries -> level=16, wr_ready=0; a 17th offer is not accepted.
  - Start -> wr_ready=1 on the cycle after the first pop.
- Stop mid-run: 4 entries of count 10, stop at the 5th cycle of entry 2 -> ttl_out=0 next cycle, level=0, done never asserted; a later start with empty FIFO does nothing.
- Loop (TTL_PULSE_SEQ_LOOP_EN): entries (0x03,2), (0x0C,1), start with loop=1 -> 03,03,0C repeats ≥3 periods; stop -> ttl_out=0, level=0.

Source files
------------

// File: rtl/ttl_pulse_sequencer.sv
// ttl_pulse_sequencer: buffers (pattern, duration) entries in a FIFO and plays
// them back-to-back on the TTL lines with cycle-exact dwell times.
// Optional build macro: TTL_PULSE_SEQ_LOOP_EN adds the 'loop' input; a looped
// playback re-writes every popped entry to the FIFO tail until stopped.
module ttl_pulse_sequencer #(
    parameter int TTL_W = 8,
    parameter int CNT_W = 32,
    parameter int DEPTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [TTL_W-1:0]         wr_pattern,
    input  logic [CNT_W-1:0]         wr_count,
    input  logic                     start,
    input  logic                     stop,
`ifdef TTL_PULSE_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    output logic [TTL_W-1:0]         ttl_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic [TTL_W-1:0] mem_pattern [DEPTH];
    logic [CNT_W-1:0] mem_count   [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_next, rd_ptr_next, level_next;
    logic [TTL_W-1:0] hold_pattern;
    logic [CNT_W-1:0] hold_count;
    logic [CNT_W-1:0] cnt;
    logic [TTL_W-1:0] head_pattern;
    logic [CNT_W-1:0] head_count;
    logic             empty;
    logic             pop;
    logic             push_ext;
    logic             loop_in;
    logic             loop_q;
    logic             loop_next;
    logic             loop_push;
    logic [AW:0]      loop_addr;

`ifdef TTL_PULSE_SEQ_LOOP_EN
    assign loop_in = loop;
`else
    assign loop_in = 1'b0;
`endif

    assign level        = wr_ptr - rd_ptr;
    assign empty        = (level == '0);
    assign head_pattern = mem_pattern[rd_ptr[AW-1:0]];
    assign head_count   = mem_count[rd_ptr[AW-1:0]];
    assign push_ext     = wr_valid && wr_ready && !stop;
    assign loop_push    = pop && ((state == IDLE) ? loop_in : loop_q);
    assign loop_addr    = wr_ptr + (AW+1)'(push_ext);

    // Pop decision and next FIFO pointers; stop flushes and overrides everything
    always_comb begin
        pop = 1'b0;
        if (!stop) begin
            if (state == IDLE && start && !empty)
                pop = 1'b1;
            if (state == RUN && cnt == CNT_W'(1) && !empty)
                pop = 1'b1;
        end
        wr_ptr_next = wr_ptr + (AW+1)'(push_ext) + (AW+1)'(loop_push);
        rd_ptr_next = rd_ptr + (AW+1)'(pop);
        loop_next   = loop_q;
        if (state == IDLE && pop)
            loop_next = loop_in;
        if (stop) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            loop_next   = 1'b0;
        end
        level_next = wr_ptr_next - rd_ptr_next;
    end

    // FIFO storage; a looped pop lands behind any external write of the same cycle
    always_ff @(posedge ACLK) begin
        if (push_ext) begin
            mem_pattern[wr_ptr[AW-1:0]] <= wr_pattern;
            mem_count[wr_ptr[AW-1:0]]   <= wr_count;
        end
        if (loop_push) begin
            mem_pattern[loop_addr[AW-1:0]] <= head_pattern;
            mem_count[loop_addr[AW-1:0]]   <= head_count;
        end
    end

    // FIFO pointers, registered wr_ready (from next occupancy) and loop flag
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_ready <= 1'b0;
            loop_q   <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            wr_ready <= (level_next != (AW+1)'(DEPTH)) && !loop_next;
            loop_q   <= loop_next;
        end
    end

    // Playback FSM with registered ttl_out/busy/done; RUN reloads in place at cnt==1
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state        <= IDLE;
            ttl_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cnt          <= '0;
            hold_pattern <= '0;
            hold_count   <= '0;
        end else if (stop) begin
            state   <= IDLE;
            ttl_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    ttl_out <= '0;
                    if (pop) begin
                        hold_pattern <= head_pattern;
                        hold_count   <= head_count;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    ttl_out <= hold_pattern;
                    cnt     <= (hold_count == '0) ? CNT_W'(1) : hold_count;
                    state   <= RUN;
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!empty) begin
                            ttl_out <= head_pattern;
                            cnt     <= (head_count == '0) ? CNT_W'(1) : head_count;
                        end else begin
                            ttl_out <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ttl_pulse_sequencer.sv
// Scoreboard bench for ttl_pulse_sequencer: stimulus pushes the expected
// per-cycle output stream at start; a negedge monitor pops and compares.
module tb_ttl_pulse_sequencer;

    logic        ACLK;
    logic        ARESET;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_pattern;
    logic [31:0] wr_count;
    logic        start;
    logic        stop;
    logic [7:0]  ttl_out;
    logic        busy;
    logic        done;
    logic [4:0]  level;
`ifdef TTL_PULSE_SEQ_LOOP_EN
    logic        loop;
`endif

    ttl_pulse_sequencer #(.TTL_W(8), .CNT_W(32), .DEPTH(16)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_pattern (wr_pattern),
        .wr_count   (wr_count),
        .start      (start),
        .stop       (stop),
`ifdef TTL_PULSE_SEQ_LOOP_EN
        .loop       (loop),
`endif
        .ttl_out    (ttl_out),
        .busy       (busy),
        .done       (done),
        .level      (level)
    );

    typedef struct packed {
        logic [7:0]  p;
        logic [31:0] c;
    } entry_t;

    typedef struct packed {
        logic [7:0] ttl;
        logic       busy;
        logic       done;
    } exp_t;

    entry_t mf[$];   // reference FIFO contents
    exp_t   sb[$];   // expected per-cycle stream while busy/done
    int     checks = 0;
    int     errors = 0;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every busy/done cycle must match the next scoreboard item
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESET !== 1'b1) begin
                checks++;
                if (busy || done) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL stream_extra got ttl=%h busy=%b done=%b expected idle", ttl_out, busy, done);
                    end else begin
                        e = sb.pop_front();
                        if (ttl_out !== e.ttl || busy !== e.busy || done !== e.done) begin
                            errors++;
                            $display("FAIL stream got ttl=%h busy=%b done=%b expected ttl=%h busy=%b done=%b",
                                     ttl_out, busy, done, e.ttl, e.busy, e.done);
                        end
                    end
                end else if (ttl_out !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_ttl got=%h expected=00", ttl_out);
                end
            end
        end
    end

    function automatic int unsigned dwell(input logic [31:0] c);
        return (c == 0) ? 1 : c;
    endfunction

    task automatic push_entry_items(input entry_t en);
        exp_t it;
        it = {en.p, 1'b1, 1'b0};
        for (int unsigned k = 0; k < dwell(en.c); k++) sb.push_back(it);
    endtask

    task automatic write_entry(input logic [7:0] p, input logic [31:0] c);
        bit acc;
        entry_t en;
        acc = 0;
        wr_valid = 1'b1;
        wr_pattern = p;
        wr_count = c;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        if (acc) begin
            en = {p, c};
            mf.push_back(en);
        end else begin
            checks++;
            errors++;
            $display("FAIL write_timeout got=no_accept expected=accept");
        end
    endtask

    task automatic do_start();
        exp_t it;
        start = 1'b1;
        if (mf.size() > 0) begin
            it = {8'h00, 1'b1, 1'b0};
            sb.push_back(it);
            foreach (mf[i]) push_entry_items(mf[i]);
            it = {8'h00, 1'b0, 1'b1};
            sb.push_back(it);
            mf.delete();
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || done) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL playback_timeout got=pending%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        entry_t en;
        exp_t   it;
        ARESET = 1'b1;
        wr_valid = 1'b0;
        wr_pattern = '0;
        wr_count = '0;
        start = 1'b0;
        stop = 1'b0;
`ifdef TTL_PULSE_SEQ_LOOP_EN
        loop = 1'b0;
`endif
        // Reset state
        #2;
        check("rst_ttl", 32'(ttl_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h0);
        tick();
        tick();
        ARESET = 1'b0;
        check("wr_ready_before_clk", 32'(wr_ready), 32'h0);
        tick();
        check("wr_ready_after_rst", 32'(wr_ready), 32'h1);

        // Single entry
        write_entry(8'hA5, 32'd3);
        check("single_level", 32'(level), 32'd1);
        do_start();
        wait_idle(50);

        // Back-to-back, count 0 treated as 1
        write_entry(8'h01, 32'd2);
        write_entry(8'h02, 32'd0);
        write_entry(8'h04, 32'd5);
        check("b2b_level", 32'(level), 32'd3);
        do_start();
        wait_idle(50);

        // Full FIFO
        for (int i = 0; i < 16; i++) write_entry(8'($urandom_range(1, 255)), 32'($urandom_range(0, 3)));
        check("full_level", 32'(level), 32'd16);
        check("full_wr_ready", 32'(wr_ready), 32'h0);
        wr_valid = 1'b1;
        wr_pattern = 8'hEE;
        wr_count = 32'd1;
        repeat (3) tick();
        wr_valid = 1'b0;
        check("full_17th_level", 32'(level), 32'd16);
        do_start();
        check("full_pop_level", 32'(level), 32'd15);
        check("full_pop_wr_ready", 32'(wr_ready), 32'h1);
        wait_idle(200);

        // Write accepted while running extends the sequence
        write_entry(8'hF0, 32'd20);
        do_start();
        write_entry(8'h5A, 32'd2);
        check("run_write_level", 32'(level), 32'd1);
        en = mf.pop_front();
        it = {en.p, 1'b1, 1'b0};
        for (int unsigned k = 0; k < dwell(en.c); k++) sb.insert(sb.size() - 1, it);
        wait_idle(100);
        check("run_write_level_end", 32'(level), 32'd0);

        // Stop at 5th cycle of entry 2, with a write in the stop cycle
        for (int i = 0; i < 4; i++) write_entry(8'(8'h10 << i), 32'd10);
        do_start();
        repeat (15) tick();
        stop = 1'b1;
        wr_valid = 1'b1;
        wr_pattern = 8'h77;
        wr_count = 32'd4;
        tick();
        stop = 1'b0;
        wr_valid = 1'b0;
        sb.delete();
        mf.delete();
        check("stop_ttl", 32'(ttl_out), 32'h0);
        check("stop_level", 32'(level), 32'd0);
        check("stop_busy", 32'(busy), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("empty_start_busy", 32'(busy), 32'h0);

        // Stop and start together: stop wins
        write_entry(8'h99, 32'd2);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        mf.delete();
        repeat (3) tick();
        check("stop_start_level", 32'(level), 32'd0);
        check("stop_start_busy", 32'(busy), 32'h0);

        // Randomized playbacks with ignored restarts while busy
        for (int it_n = 0; it_n < 20; it_n++) begin
            int n_ent;
            n_ent = int'($urandom_range(1, 5));
            for (int i = 0; i < n_ent; i++) write_entry(8'($urandom_range(0, 255)), 32'($urandom_range(0, 6)));
            check("rnd_level", 32'(level), 32'(mf.size()));
            check("rnd_wr_ready", 32'(wr_ready), 32'h1);
            repeat ($urandom_range(0, 2)) tick();
            do_start();
            repeat ($urandom_range(0, 4)) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_idle(100);
        end

        // Reset mid-run: outputs clear without a clock edge
        write_entry(8'h3C, 32'd50);
        do_start();
        repeat (6) tick();
        #2;
        ARESET = 1'b1;
        #1;
        check("arst_ttl", 32'(ttl_out), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_level", 32'(level), 32'h0);
        sb.delete();
        mf.delete();
        tick();
        ARESET = 1'b0;
        tick();
        check("arst_release_level", 32'(level), 32'h0);
        check("arst_release_wr_ready", 32'(wr_ready), 32'h1);

`ifdef TTL_PULSE_SEQ_LOOP_EN
        // Looped playback repeats until stop
        write_entry(8'h03, 32'd2);
        write_entry(8'h0C, 32'd1);
        it = {8'h00, 1'b1, 1'b0};
        sb.push_back(it);
        for (int per = 0; per < 5; per++) foreach (mf[i]) push_entry_items(mf[i]);
        start = 1'b1;
        loop = 1'b1;
        tick();
        start = 1'b0;
        loop = 1'b0;
        check("loop_level", 32'(level), 32'd2);
        check("loop_wr_ready", 32'(wr_ready), 32'h0);
        for (int n = 0; n < 100 && sb.size() > 3; n++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        sb.delete();
        mf.delete();
        check("loop_stop_ttl", 32'(ttl_out), 32'h0);
        check("loop_stop_level", 32'(level), 32'h0);
`endif

        repeat (3) tick();
        check("final_sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
